// File: rtl/foc_dlk_pkg.sv
// Shared types and defaults for the FOC frontend deadlock report controller.
package foc_dlk_pkg;

    localparam int DEF_N_MON = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_IDX_W = $clog2(DEF_N_MON);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Report record as seen by the status block in the default configuration
    typedef struct packed {
        logic [DEF_IDX_W-1:0] idx;
        logic [DEF_CNT_W-1:0] cycles;
    } rpt_t;

    // Modular add of an offset to an index in a ring of n entries (off < n)
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/foc_dlk_persist_cnt.sv
// Per-instance saturating blocked-duration counter with a threshold-crossing pulse.
module foc_dlk_persist_cnt
    import foc_dlk_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int THRESH = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             blk,
    output logic [CNT_W-1:0] cnt,
    output logic             det
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] cnt_r;

    // Run length of consecutive blocked cycles, saturating, cleared when not blocked
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && blk) begin
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // High in the cycle whose closing edge moves cnt from THRESH-1 to THRESH,
    // so the owner registers its flags on exactly that edge.
    assign cnt = cnt_r;
    assign det = enable && blk && (cnt_r == THRESH_M1);

endmodule

// File: rtl/foc_deadlock_report_ctrl.sv
// Qualifies HLS monitor block flags, keeps sticky status and drains deadlock
// episodes round-robin onto one valid/ready report channel.
module foc_deadlock_report_ctrl
    import foc_dlk_pkg::*;
#(
    parameter int N_MON  = DEF_N_MON,
    parameter int THRESH = 1024,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int IDX_W = $clog2(N_MON)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_MON-1:0] mon_block,
    input  logic [N_MON-1:0] clear,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [IDX_W-1:0] rpt_idx,
    output logic [CNT_W-1:0] rpt_cycles,
    output logic [N_MON-1:0] sticky,
    output logic             any_deadlock
);

    logic [CNT_W-1:0] cnt_s [N_MON];
    logic [N_MON-1:0] det_s;
    logic [N_MON-1:0] pending_r;
    logic [N_MON-1:0] sticky_r;
    logic [N_MON-1:0] cap_mask_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] sel_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;
    logic             capture_s;
    state_t           state_r;
    logic             rpt_valid_r;
    logic [IDX_W-1:0] rpt_idx_r;
    logic [CNT_W-1:0] rpt_cycles_r;

    for (genvar g = 0; g < N_MON; g++) begin : g_mon
        foc_dlk_persist_cnt #(
            .CNT_W  (CNT_W),
            .THRESH (THRESH)
        ) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .enable (enable),
            .blk    (mon_block[g]),
            .cnt    (cnt_s[g]),
            .det    (det_s[g])
        );
    end

    // First pending index at or after ptr, with wrap
    always_comb begin
        sel_s   = {IDX_W{1'b0}};
        cand_s  = {IDX_W{1'b0}};
        found_s = 1'b0;
        for (int k = 0; k < N_MON; k++) begin
            cand_s = IDX_W'(wrap_add(32'(ptr_r), k, N_MON));
            if (!found_s && pending_r[cand_s]) begin
                sel_s   = cand_s;
                found_s = 1'b1;
            end else begin
                sel_s   = sel_s;
                found_s = found_s;
            end
        end
    end

    // One-hot of the pending bit taken by the scheduler this cycle
    always_comb begin
        capture_s  = (state_r == IDLE) && found_s;
        cap_mask_s = {N_MON{1'b0}};
        if (capture_s) begin
            cap_mask_s[sel_s] = 1'b1;
        end else begin
            cap_mask_s = {N_MON{1'b0}};
        end
    end

    // Pending and sticky flags; a detect on the same edge beats capture or clear
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r <= {N_MON{1'b0}};
            sticky_r  <= {N_MON{1'b0}};
        end else begin
            pending_r <= (pending_r & ~cap_mask_s) | det_s;
            sticky_r  <= (sticky_r & ~clear) | det_s;
        end
    end

    // Report scheduler FSM with registered channel outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            rpt_valid_r  <= 1'b0;
            rpt_idx_r    <= {IDX_W{1'b0}};
            rpt_cycles_r <= {CNT_W{1'b0}};
            ptr_r        <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        rpt_idx_r    <= sel_s;
                        rpt_cycles_r <= cnt_s[sel_s];
                        rpt_valid_r  <= 1'b1;
                        state_r      <= SEND;
                    end else begin
                        rpt_valid_r  <= 1'b0;
                    end
                end
                SEND: begin
                    if (rpt_ready) begin
                        ptr_r       <= IDX_W'(wrap_add(32'(rpt_idx_r), 32'd1, N_MON));
                        rpt_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        rpt_valid_r <= 1'b1;
                    end
                end
                default: begin
                    rpt_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rpt_valid    = rpt_valid_r;
    assign rpt_idx      = rpt_idx_r;
    assign rpt_cycles   = rpt_cycles_r;
    assign sticky       = sticky_r;
    assign any_deadlock = |sticky_r;

endmodule

// File: tb/tb_foc_deadlock_report_ctrl.sv
// Scoreboard bench: stimulus queues expected reports, monitors check each handshake.
module tb_foc_deadlock_report_ctrl;

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance: N_MON=8, THRESH=4, CNT_W=16
    logic        reset, enable, rpt_ready;
    logic [7:0]  mon_block, clear;
    logic        rpt_valid, any_deadlock;
    logic [2:0]  rpt_idx;
    logic [15:0] rpt_cycles;
    logic [7:0]  sticky;

    // Saturation instance: N_MON=2, THRESH=3, CNT_W=4
    logic        reset2, enable2, ready2;
    logic [1:0]  mon2, clear2;
    logic        valid2, any2;
    logic [0:0]  idx2;
    logic [3:0]  cycles2;
    logic [1:0]  sticky2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   n_checks = 0;
    int   n_err    = 0;

    foc_deadlock_report_ctrl #(.N_MON(8), .THRESH(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mon_block(mon_block),
        .clear(clear), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_idx(rpt_idx), .rpt_cycles(rpt_cycles), .sticky(sticky),
        .any_deadlock(any_deadlock)
    );

    foc_deadlock_report_ctrl #(.N_MON(2), .THRESH(3), .CNT_W(4)) dut2 (
        .clock(clock), .reset(reset2), .enable(enable2), .mon_block(mon2),
        .clear(clear2), .rpt_valid(valid2), .rpt_ready(ready2),
        .rpt_idx(idx2), .rpt_cycles(cycles2), .sticky(sticky2),
        .any_deadlock(any2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic push1(input int idx, input int cyc);
        exp_t e;
        e.idx = idx;
        e.cyc = cyc;
        q1.push_back(e);
    endtask

    task automatic push2(input int idx, input int cyc);
        exp_t e;
        e.idx = idx;
        e.cyc = cyc;
        q2.push_back(e);
    endtask

    // Monitor for the main instance: every handshake must match the queue head
    always @(negedge clock) begin
        if (!reset && rpt_valid && rpt_ready) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rpt: got idx=%0d cycles=%0d, none expected at %0t", rpt_idx, rpt_cycles, $time);
            end else begin
                e1 = q1.pop_front();
                chk("rpt_idx", int'(rpt_idx), e1.idx);
                chk("rpt_cycles", int'(rpt_cycles), e1.cyc);
            end
        end
    end

    // Monitor for the saturation instance
    always @(negedge clock) begin
        if (!reset2 && valid2 && ready2) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rpt2: got idx=%0d cycles=%0d, none expected at %0t", idx2, cycles2, $time);
            end else begin
                e2 = q2.pop_front();
                chk("rpt_idx2", int'(idx2), e2.idx);
                chk("rpt_cycles2", int'(cycles2), e2.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; rpt_ready = 1'b1; mon_block = 8'h00; clear = 8'h00;
        reset2 = 1'b1; enable2 = 1'b1; ready2 = 1'b1; mon2 = 2'b00; clear2 = 2'b00;
        tick(3);
        chk("reset_valid", int'(rpt_valid), 0);
        chk("reset_idx", int'(rpt_idx), 0);
        chk("reset_cycles", int'(rpt_cycles), 0);
        chk("reset_sticky", int'(sticky), 0);
        chk("reset_any", int'(any_deadlock), 0);
        reset = 1'b0;

        // Below threshold: three blocked cycles never qualify
        mon_block = 8'h08;
        tick(3);
        mon_block = 8'h00;
        tick(5);
        chk("short_sticky", int'(sticky), 0);
        chk("short_any", int'(any_deadlock), 0);

        // Single deadlock on 5: detect on edge 4, valid on edge 5
        rpt_ready = 1'b0;
        mon_block = 8'h20;
        push1(5, 4);
        tick(4);
        chk("det_edge_valid", int'(rpt_valid), 0);
        chk("det_edge_sticky", int'(sticky), 8'h20);
        tick(1);
        chk("valid_edge5", int'(rpt_valid), 1);
        chk("idx_edge5", int'(rpt_idx), 5);
        chk("cycles_edge5", int'(rpt_cycles), 4);
        mon_block = 8'h00;
        rpt_ready = 1'b1;
        tick(3);
        chk("sticky5_held", int'(sticky), 8'h20);
        chk("any5_held", int'(any_deadlock), 1);

        // Reset clears sticky and ptr; simultaneous detect on 1,2,6 drains in order from 0
        reset = 1'b1;
        tick(2);
        chk("reset_sticky2", int'(sticky), 0);
        reset = 1'b0;
        mon_block = 8'h46;
        push1(1, 4); push1(2, 6); push1(6, 8);
        tick(10);
        mon_block = 8'h00;
        tick(3);

        // Move ptr to 2 with a lone report on 1, then the same burst drains 2,6,1
        mon_block = 8'h02;
        push1(1, 4);
        tick(4);
        mon_block = 8'h00;
        tick(4);
        mon_block = 8'h46;
        push1(2, 4); push1(6, 6); push1(1, 8);
        tick(10);
        mon_block = 8'h00;
        tick(3);

        // Backpressure: report on 0 held stable while 4 detects and waits
        rpt_ready = 1'b0;
        mon_block = 8'h01;
        push1(0, 4);
        tick(5);
        chk("stall_valid_start", int'(rpt_valid), 1);
        mon_block = 8'h10;
        push1(4, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i == 3) mon_block = 8'h00;
            chk("stall_valid", int'(rpt_valid), 1);
            chk("stall_idx", int'(rpt_idx), 0);
            chk("stall_cycles", int'(rpt_cycles), 4);
        end
        rpt_ready = 1'b1;
        tick(6);
        chk("sticky_after_stall", int'(sticky), 8'h57);

        // Clear colliding with detect keeps sticky; a lone clear drops it
        mon_block = 8'h20;
        tick(3);
        clear = 8'h20;
        push1(5, 4);
        tick(1);
        clear = 8'h00;
        mon_block = 8'h00;
        chk("clear_vs_detect", int'(sticky[5]), 1);
        tick(3);
        clear = 8'h20;
        tick(1);
        clear = 8'h00;
        chk("clear5_sticky", int'(sticky), 8'h57);
        chk("clear5_any", int'(any_deadlock), 1);
        clear = 8'hFF;
        tick(1);
        clear = 8'h00;
        chk("clear_all_sticky", int'(sticky), 0);
        chk("clear_all_any", int'(any_deadlock), 0);

        // Disabled counting never detects; an already-captured report still drains
        enable = 1'b0;
        mon_block = 8'hFF;
        tick(6);
        chk("disabled_sticky", int'(sticky), 0);
        enable = 1'b1;
        mon_block = 8'h00;
        rpt_ready = 1'b0;
        mon_block = 8'h08;
        push1(3, 4);
        tick(5);
        enable = 1'b0;
        mon_block = 8'h00;
        tick(2);
        chk("drain_valid", int'(rpt_valid), 1);
        chk("drain_idx", int'(rpt_idx), 3);
        rpt_ready = 1'b1;
        enable = 1'b1;
        tick(3);

        // Saturation instance: long episode gives one report per instance, cycles cap at 15
        reset2 = 1'b0;
        mon2 = 2'b11;
        ready2 = 1'b0;
        push2(0, 3);
        tick(4);
        chk("sat_valid", int'(valid2), 1);
        chk("sat_idx", int'(idx2), 0);
        chk("sat_cycles", int'(cycles2), 3);
        tick(20);
        ready2 = 1'b1;
        push2(1, 15);
        tick(20);
        mon2 = 2'b00;
        tick(3);
        chk("sat_sticky", int'(sticky2), 3);

        // Reset during SEND drops the in-flight report
        ready2 = 1'b0;
        mon2 = 2'b01;
        tick(4);
        chk("pre_reset_valid2", int'(valid2), 1);
        reset2 = 1'b1;
        mon2 = 2'b00;
        tick(2);
        chk("reset_valid2", int'(valid2), 0);
        reset2 = 1'b0;
        ready2 = 1'b1;
        tick(8);
        chk("post_reset_valid2", int'(valid2), 0);
        chk("post_reset_sticky2", int'(sticky2), 0);

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
